switch_hit_checker: RTL and testbench
=====================================

SWITCH_HIT_CHECKER -- requirements
Module: switch_hit_checker

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 18: number of LED/switch positions.
REQ-002 SHALL have parameter SCALE_FACTOR, default 50000: CLOCK_50 cycles per millisecond.
REQ-003 SHALL have parameter DEBOUNCE_MS, default 10: debounce sample interval in ms.
REQ-004 SHALL have port CLOCK_50, input, 1: single system clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1: game running; events are scored only while high.
REQ-007 SHALL have port score_clear, input, 1: synchronous score clear.
REQ-008 SHALL have port target, input, NUM_LEDS: currently lit LED pattern (LEDR).
REQ-009 SHALL have port sw_raw, input, NUM_LEDS: raw asynchronous slide switches (SW).
REQ-010 SHALL have port hit_valid, output, 1: one-cycle pulse, toggle on a lit position.
REQ-011 SHALL have port miss_valid, output, 1: one-cycle pulse, toggle on an unlit position.
REQ-012 SHALL have port hit_index, output, 5: position of the last hit or miss.
REQ-013 SHALL have port target_clear, output, NUM_LEDS: one-hot, one-cycle mask of the position just hit.
REQ-014 SHALL have port score, output, 11: running hit count.

Function
REQ-015 Each sw_raw bit SHALL pass through a 2-FF synchronizer.
REQ-016 A free-running tick SHALL pulse once every DEBOUNCE_MS*SCALE_FACTOR cycles.
REQ-017 The debounced bit SHALL update only when the synchronized value is equal at two consecutive ticks.
REQ-018 A change of a debounced bit, in either direction, SHALL set that bit in a pending mask.
REQ-019 FSM states SHALL be INIT, IDLE and RUN.
REQ-020 INIT: debounced state loads with no events. INIT→IDLE after two ticks.
REQ-021 IDLE→RUN when enable=1; RUN→IDLE when enable=0.
REQ-022 In IDLE the pending mask SHALL be held at zero; debouncing SHALL continue.
REQ-023 In RUN, once per cycle, the lowest-index pending bit i SHALL be consumed and cleared.
REQ-024 If target[i]=1 in the consuming cycle: hit_valid=1, target_clear=1<<i, score+1, saturating at 2047.
REQ-025 If target[i]=0 in the consuming cycle: miss_valid=1.
REQ-026 hit_index SHALL be set to i on every hit or miss and held otherwise.
REQ-027 Latency: a pending bit set in cycle N, if lowest, SHALL produce its pulse in cycle N+1.
REQ-028 Multiple bits pending SHALL be served in ascending index order, one per cycle.
REQ-029 A new toggle on an already-pending bit SHALL cancel it (net no change); a new toggle on a non-pending bit is simply queued.
REQ-030 score_clear SHALL zero score and take priority over a same-cycle hit.
REQ-031 hit_valid and miss_valid SHALL never both be 1 in the same cycle.

Reset
REQ-032 On reset_n=0, asynchronously: FSM=INIT; all outputs, pending mask, debounced state, synchronizers and tick counter = 0.
REQ-033 A mid-game reset SHALL discard pending events and SHALL re-enter INIT, so current switch positions are not scored.

Configuration
REQ-034 Macro MISS_PENALTY_EN defined: each miss SHALL also decrement score, saturating at 0; score_clear still wins.
REQ-035 Macro MISS_PENALTY_EN undefined: a miss SHALL only pulse miss_valid; score is unchanged.

Structure
REQ-036 Package game_pkg SHALL hold NUM_LEDS_DEFAULT, SCORE_W=11, IDX_W=5, the led_mask_t and score_t typedefs, and the FSM state enum.
REQ-037 The synchronizer, tick counter and per-bit debounce SHALL live in sub-module switch_debouncer, which outputs the debounced vector and a one-cycle change mask.

Verification (SCALE_FACTOR=1, DEBOUNCE_MS=4 unless stated)
REQ-038 Reset release with sw_raw=18'h00005 -> no hit or miss pulses after INIT; score=0.
REQ-039 RUN, target[3]=1, toggle sw_raw[3] -> exactly one hit_valid; hit_index=3; target_clear=18'h00008; score 0→1.
REQ-040 RUN, target=0, toggle sw_raw[7] -> one miss_valid; score unchanged; with MISS_PENALTY_EN and score=5 -> score=4.
REQ-041 Toggle sw_raw[2], [9] and [15] in the same cycle, all lit -> hits in consecutive cycles with hit_index 2, 9, 15; score +3.
REQ-042 sw_raw[4] glitch held 2 cycles, then restored -> no event; score preloaded to 2047 plus one hit -> score stays 2047.
REQ-043 score_clear coincident with a hit -> score=0; reset asserted with events pending -> no pulses after release.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the switch-hit game logic.
// Contents: default LED count, score/index widths, score saturation value,
// LED mask / score typedefs and the scoring FSM state encoding.
package game_pkg;

    localparam int NUM_LEDS_DEFAULT = 18;
    localparam int SCORE_W          = 11;
    localparam int IDX_W            = 5;

    typedef logic [NUM_LEDS_DEFAULT-1:0] led_mask_t;
    typedef logic [SCORE_W-1:0]          score_t;

    localparam score_t SCORE_MAX = '1;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/switch_debouncer.sv
// Synchronizes and debounces a vector of raw slide switches.
// Ports:
//   clk, rst_n  - system clock (rising edge), async active-low reset
//   sw_raw      - raw asynchronous switch inputs
//   tick        - one-cycle pulse every DEBOUNCE_MS*SCALE_FACTOR cycles
//   debounced   - debounced switch levels
//   change      - one-cycle mask of bits whose debounced level just flipped
// A bit's debounced level only follows the synchronized input once the
// same value has been seen at two consecutive ticks.
module switch_debouncer #(
    parameter int NUM_LEDS     = 18,
    parameter int SCALE_FACTOR = 50000,
    parameter int DEBOUNCE_MS  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_LEDS-1:0] sw_raw,
    output logic                tick,
    output logic [NUM_LEDS-1:0] debounced,
    output logic [NUM_LEDS-1:0] change
);

    localparam int TICK_CYC = DEBOUNCE_MS * SCALE_FACTOR;
    localparam int CNT_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    logic [CNT_W-1:0]    tick_cnt;
    logic [NUM_LEDS-1:0] sync1, sync2;
    logic [NUM_LEDS-1:0] sample;
    logic [NUM_LEDS-1:0] stable;
    logic [NUM_LEDS-1:0] deb_next;

    assign tick = (tick_cnt == CNT_W'(TICK_CYC - 1));

    // Bits that matched the previous tick's sample take the new value;
    // everything else keeps its current debounced level.
    always_comb begin
        stable   = ~(sync2 ^ sample);
        deb_next = (stable & sync2) | (~stable & debounced);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            sync1     <= '0;
            sync2     <= '0;
            sample    <= '0;
            debounced <= '0;
            change    <= '0;
        end else begin
            sync1    <= sw_raw;
            sync2    <= sync1;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                sample    <= sync2;
                debounced <= deb_next;
                change    <= deb_next ^ debounced;
            end else begin
                change    <= '0;
            end
        end
    end

endmodule

// File: rtl/switch_hit_checker.sv
// Scores switch toggles against the currently lit LED pattern.
// Ports:
//   CLOCK_50     - system clock, rising edge
//   reset_n      - async active-low reset
//   enable       - game running; events scored only while high
//   score_clear  - synchronous score clear (beats a same-cycle hit)
//   target       - lit LED pattern
//   sw_raw       - raw slide switches
//   hit_valid    - one-cycle pulse: toggled switch was lit
//   miss_valid   - one-cycle pulse: toggled switch was unlit
//   hit_index    - position of the last hit or miss
//   target_clear - one-hot one-cycle mask of the position just hit
//   score        - saturating hit count
// Build option: define MISS_PENALTY_EN to make each miss decrement the
// score (saturating at zero).
// Debounced toggles collect in a pending mask; in RUN the lowest pending
// bit is served each cycle. A second toggle on a still-pending bit XORs it
// back out, so a quick flip-and-return scores nothing.
module switch_hit_checker
    import game_pkg::*;
#(
    parameter int NUM_LEDS     = NUM_LEDS_DEFAULT,
    parameter int SCALE_FACTOR = 50000,
    parameter int DEBOUNCE_MS  = 10
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                score_clear,
    input  logic [NUM_LEDS-1:0] target,
    input  logic [NUM_LEDS-1:0] sw_raw,
    output logic                hit_valid,
    output logic                miss_valid,
    output logic [IDX_W-1:0]    hit_index,
    output logic [NUM_LEDS-1:0] target_clear,
    output logic [SCORE_W-1:0]  score
);

    state_t              state;
    logic                init_tick_seen;
    logic                tick;
    logic [NUM_LEDS-1:0] change;
    logic [NUM_LEDS-1:0] pending;
    // Levels are not needed here; scoring is driven purely by the change mask.
    logic [NUM_LEDS-1:0] deb_level_unused;

    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [NUM_LEDS-1:0] sel_mask;
    logic                hit_evt;
    logic                miss_evt;

    switch_debouncer #(
        .NUM_LEDS     (NUM_LEDS),
        .SCALE_FACTOR (SCALE_FACTOR),
        .DEBOUNCE_MS  (DEBOUNCE_MS)
    ) u_deb (
        .clk       (CLOCK_50),
        .rst_n     (reset_n),
        .sw_raw    (sw_raw),
        .tick      (tick),
        .debounced (deb_level_unused),
        .change    (change)
    );

    // Lowest-index pending bit: scan downward so the last match wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_mask  = '0;
        for (int i = NUM_LEDS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_found   = 1'b1;
                sel_idx     = IDX_W'(i);
                sel_mask    = '0;
                sel_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        hit_evt  = 1'b0;
        miss_evt = 1'b0;
        if (state == RUN && enable && sel_found) begin
            if (target[sel_idx]) hit_evt  = 1'b1;
            else                 miss_evt = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state          <= INIT;
            init_tick_seen <= 1'b0;
            pending        <= '0;
            hit_valid      <= 1'b0;
            miss_valid     <= 1'b0;
            hit_index      <= '0;
            target_clear   <= '0;
            score          <= '0;
        end else begin
            hit_valid    <= hit_evt;
            miss_valid   <= miss_evt;
            target_clear <= hit_evt ? sel_mask : '0;
            if (hit_evt || miss_evt) hit_index <= sel_idx;

            case (state)
                // Let the debouncer settle on the power-up switch positions
                // so they are never reported as toggles.
                INIT: begin
                    pending <= '0;
                    if (tick) begin
                        if (init_tick_seen) begin
                            state          <= IDLE;
                            init_tick_seen <= 1'b0;
                        end else begin
                            init_tick_seen <= 1'b1;
                        end
                    end
                end
                IDLE: begin
                    pending <= '0;
                    if (enable) state <= RUN;
                end
                RUN: begin
                    if (!enable) begin
                        state   <= IDLE;
                        pending <= '0;
                    end else begin
                        pending <= (pending & ~sel_mask) ^ change;
                    end
                end
                default: begin
                    state   <= INIT;
                    pending <= '0;
                end
            endcase

            if (score_clear) begin
                score <= '0;
            end else if (hit_evt) begin
                if (score != SCORE_MAX) score <= score + 1'b1;
            end
`ifdef MISS_PENALTY_EN
            else if (miss_evt) begin
                if (score != '0) score <= score - 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_switch_hit_checker.sv
// Directed, table-driven bench for switch_hit_checker (SCALE_FACTOR=1,
// DEBOUNCE_MS=4). Expectations follow MISS_PENALTY_EN when defined.
module tb_switch_hit_checker;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        score_clear;
    logic [17:0] target;
    logic [17:0] sw_raw;
    logic        hit_valid;
    logic        miss_valid;
    logic [4:0]  hit_index;
    logic [17:0] target_clear;
    logic [10:0] score;

    switch_hit_checker #(
        .NUM_LEDS     (18),
        .SCALE_FACTOR (1),
        .DEBOUNCE_MS  (4)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset_n      (reset_n),
        .enable       (enable),
        .score_clear  (score_clear),
        .target       (target),
        .sw_raw       (sw_raw),
        .hit_valid    (hit_valid),
        .miss_valid   (miss_valid),
        .hit_index    (hit_index),
        .target_clear (target_clear),
        .score        (score)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int hit_cnt = 0;
    int miss_cnt = 0;
    int log_n = 0;
    int log_idx [0:31];
    int log_cyc [0:31];
    logic [17:0] last_tclr = '0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    always @(posedge CLOCK_50) cyc_cnt++;

    // Event monitor: counts pulses, logs order/timing, checks exclusivity
    // and the one-hot clear mask on each hit.
    always @(negedge CLOCK_50) begin
        if (hit_valid && miss_valid) chk("hit_and_miss_same_cycle", 1, 0);
        if (hit_valid || miss_valid) begin
            if (log_n < 32) begin
                log_idx[log_n] = int'(hit_index);
                log_cyc[log_n] = cyc_cnt;
            end
            log_n++;
        end
        if (hit_valid) begin
            hit_cnt++;
            last_tclr = target_clear;
            chk("target_clear_onehot", int'(target_clear), int'(18'd1 << hit_index));
        end
        if (miss_valid) begin
            miss_cnt++;
            chk("miss_no_target_clear", int'(target_clear), 0);
        end
    end

    typedef struct {
        logic [17:0] tgt;
        logic [17:0] toggle;
        int          hits;
        int          misses;
        int          score;
        int          n;
        int          i0, i1, i2;
        logic [17:0] tclr;
    } vec_t;

    vec_t tv [0:4];

    initial begin
        int h0, m0, exp_idx[3], base_score;
        logic [17:0] tmp;

`ifdef MISS_PENALTY_EN
        tv[0] = '{18'h00008, 18'h00008, 1, 0, 1, 1, 3, -1, -1, 18'h00008};
        tv[1] = '{18'h00000, 18'h00080, 0, 1, 0, 1, 7, -1, -1, 18'h00000};
        tv[2] = '{18'h08204, 18'h08204, 3, 0, 3, 3, 2, 9, 15, 18'h08000};
        tv[3] = '{18'h00001, 18'h00001, 1, 0, 4, 1, 0, -1, -1, 18'h00001};
        tv[4] = '{18'h20000, 18'h30000, 1, 1, 4, 2, 16, 17, -1, 18'h20000};
`else
        tv[0] = '{18'h00008, 18'h00008, 1, 0, 1, 1, 3, -1, -1, 18'h00008};
        tv[1] = '{18'h00000, 18'h00080, 0, 1, 1, 1, 7, -1, -1, 18'h00000};
        tv[2] = '{18'h08204, 18'h08204, 3, 0, 4, 3, 2, 9, 15, 18'h08000};
        tv[3] = '{18'h00001, 18'h00001, 1, 0, 5, 1, 0, -1, -1, 18'h00001};
        tv[4] = '{18'h20000, 18'h30000, 1, 1, 6, 2, 16, 17, -1, 18'h20000};
`endif

        reset_n = 1'b0; enable = 1'b1; score_clear = 1'b0;
        target = '0; sw_raw = 18'h00005;
        cyc(3);
        chk("rst_hit_valid", int'(hit_valid), 0);
        chk("rst_miss_valid", int'(miss_valid), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_target_clear", int'(target_clear), 0);
        chk("rst_hit_index", int'(hit_index), 0);

        // Power-up switch positions must not be scored.
        reset_n = 1'b1;
        cyc(40);
        chk("init_no_hits", hit_cnt, 0);
        chk("init_no_misses", miss_cnt, 0);
        chk("init_score", int'(score), 0);

        for (int k = 0; k < 5; k++) begin
            target = tv[k].tgt;
            cyc(1);
            h0 = hit_cnt; m0 = miss_cnt; log_n = 0;
            sw_raw = sw_raw ^ tv[k].toggle;
            cyc(40);
            chk($sformatf("v%0d_hits", k), hit_cnt - h0, tv[k].hits);
            chk($sformatf("v%0d_misses", k), miss_cnt - m0, tv[k].misses);
            chk($sformatf("v%0d_score", k), int'(score), tv[k].score);
            chk($sformatf("v%0d_events", k), log_n, tv[k].n);
            exp_idx[0] = tv[k].i0; exp_idx[1] = tv[k].i1; exp_idx[2] = tv[k].i2;
            for (int j = 0; j < tv[k].n && j < log_n; j++) begin
                chk($sformatf("v%0d_idx%0d", k, j), log_idx[j], exp_idx[j]);
                chk($sformatf("v%0d_cyc%0d", k, j), log_cyc[j] - log_cyc[0], j);
            end
            chk($sformatf("v%0d_hit_index", k), int'(hit_index), exp_idx[tv[k].n - 1]);
            if (tv[k].hits > 0)
                chk($sformatf("v%0d_target_clear", k), int'(last_tclr), int'(tv[k].tclr));
        end
        base_score = int'(score);

        // Toggle while the game is stopped: dropped, even after re-enable.
        enable = 1'b0;
        target = 18'h3FFFF;
        cyc(2);
        h0 = hit_cnt; m0 = miss_cnt;
        sw_raw[5] = ~sw_raw[5];
        cyc(40);
        enable = 1'b1;
        cyc(30);
        chk("idle_no_hits", hit_cnt - h0, 0);
        chk("idle_no_misses", miss_cnt - m0, 0);
        chk("idle_score", int'(score), base_score);

        // Two-cycle glitch is shorter than two tick samples.
        h0 = hit_cnt; m0 = miss_cnt;
        sw_raw[4] = ~sw_raw[4];
        cyc(2);
        sw_raw[4] = ~sw_raw[4];
        cyc(40);
        chk("glitch_no_hits", hit_cnt - h0, 0);
        chk("glitch_no_misses", miss_cnt - m0, 0);

        // Drive the score into saturation with rounds of 18 lit toggles.
        h0 = hit_cnt;
        for (int r = 0; r < 114; r++) begin
            sw_raw = sw_raw ^ 18'h3FFFF;
            cyc(40);
        end
        chk("sat_hits", hit_cnt - h0, 114 * 18);
        chk("sat_score", int'(score), 2047);
        h0 = hit_cnt;
        sw_raw[4] = ~sw_raw[4];
        cyc(40);
        chk("sat_extra_hit", hit_cnt - h0, 1);
        chk("sat_score_hold", int'(score), 2047);

        // score_clear lands on the cycle the second of three hits is consumed.
        target = 18'h0000E;
        h0 = hit_cnt;
        tmp = 18'h0000E;
        sw_raw = sw_raw ^ tmp;
        for (int w = 0; w < 60 && !hit_valid; w++) @(negedge CLOCK_50);
        chk("clr_wait_first_hit", int'(hit_valid), 1);
        score_clear = 1'b1;
        @(negedge CLOCK_50);
        score_clear = 1'b0;
        cyc(20);
        chk("clr_hits", hit_cnt - h0, 3);
        chk("clr_priority_score", int'(score), 1);

        // Reset with a queue of pending hits: nothing reported afterwards.
        target = 18'h3FFFF;
        sw_raw = sw_raw ^ 18'h3FFFF;
        for (int w = 0; w < 60 && !hit_valid; w++) @(negedge CLOCK_50);
        chk("mid_wait_first_hit", int'(hit_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_async_score", int'(score), 0);
        chk("mid_async_hit_valid", int'(hit_valid), 0);
        cyc(3);
        chk("mid_target_clear", int'(target_clear), 0);
        h0 = hit_cnt; m0 = miss_cnt;
        reset_n = 1'b1;
        cyc(60);
        chk("mid_no_hits", hit_cnt - h0, 0);
        chk("mid_no_misses", miss_cnt - m0, 0);
        chk("mid_score", int'(score), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
